// File: rtl/switch_in_stage_if.sv
// switch_in_stage_if: handshake/bus bundle between the traffic sources, the
// ingress stage and the downstream barrel shifter.
// The master modport drives the request side (en, in_valid, in_dst, in_data).
// The slave modport (switch_in_stage) drives in_ready, sel_out and port_out.
// Port count and payload width default to `PORT_NUB_TOTAL / `DATA_WIDTH when
// those macros are not supplied by the build.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface switch_in_stage_if #(
    parameter int N = `PORT_NUB_TOTAL,
    parameter int D = `DATA_WIDTH
);
    localparam int SW = $clog2(N);
    localparam int PW = 1 + 2 * SW + D;

    logic            en;
    logic [N-1:0]    in_valid;
    logic [N*SW-1:0] in_dst;
    logic [N*D-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic [SW-1:0]   sel_out;
    logic [N*PW-1:0] port_out;

    modport master (
        output en, in_valid, in_dst, in_data,
        input  in_ready, sel_out, port_out
    );

    modport slave (
        input  en, in_valid, in_dst, in_data,
        output in_ready, sel_out, port_out
    );
endinterface

// File: rtl/switch_in_stage.sv
// switch_in_stage: ingress stage of the shared-cache switch.
// One small FIFO per input port; on every enabled cycle each non-empty FIFO
// pops its head into a registered slot {valid, src_id, dst_id, data} and the
// rotation select for the barrel shifter advances by one, so both reach the
// shifter on the same edge. With en low all slots are cleared and the select
// holds.
// Optional feature: define SWITCH_IN_DROP_CNT_EN to add per-port 16-bit
// saturating counters (drop_cnt) of cycles where a port offered a word while
// its FIFO was full.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module switch_in_stage #(
    parameter int PORT_NUM   = `PORT_NUB_TOTAL,
    parameter int DATA_W     = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    switch_in_stage_if.slave  bus
`ifdef SWITCH_IN_DROP_CNT_EN
    ,
    output logic [PORT_NUM*16-1:0] drop_cnt
`endif
);
    localparam int WIDTH_SEL  = $clog2(PORT_NUM);
    localparam int WIDTH_PORT = 1 + 2 * WIDTH_SEL + DATA_W;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int WW         = WIDTH_SEL + DATA_W;   // stored word: {dst, data}

    localparam logic [AW:0]          PTR_ONE = 1;
    localparam logic [WIDTH_SEL-1:0] SEL_ONE = 1;

    logic [WIDTH_SEL-1:0] sel_q, sel_d;

    // Select advances once per enabled cycle; power-of-two N wraps naturally.
    always_comb begin
        sel_d = sel_q;
        if (bus.en) begin
            sel_d = sel_q + SEL_ONE;
        end
    end

    // Rotation select register, aligned with the slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign bus.sel_out = sel_q;

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
            localparam logic [WIDTH_SEL-1:0] SRC_ID = WIDTH_SEL'(gi);

            logic [WW-1:0]         mem_q [FIFO_DEPTH];
            logic [AW:0]           wr_q, wr_d;
            logic [AW:0]           rd_q, rd_d;
            logic [WIDTH_PORT-1:0] slot_q, slot_d;
            logic                  full;
            logic                  empty;
            logic                  push;
            logic                  pop;
            logic [WW-1:0]         head;

            // Extra pointer MSB distinguishes full from empty when indices match.
            assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
            assign empty = (wr_q == rd_q);
            // Push depends only on pre-edge fullness, so a same-cycle pop
            // never frees room for a word offered while full.
            assign push  = bus.in_valid[gi] && !full;
            assign pop   = bus.en && !empty;
            assign head  = mem_q[rd_q[AW-1:0]];

            assign bus.in_ready[gi] = !full;
            assign bus.port_out[gi*WIDTH_PORT +: WIDTH_PORT] = slot_q;

            // Next pointers and next slot word for this port.
            always_comb begin
                wr_d   = wr_q;
                rd_d   = rd_q;
                slot_d = '0;
                if (push) begin
                    wr_d = wr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_d   = rd_q + PTR_ONE;
                    slot_d = {1'b1, SRC_ID, head};
                end
            end

            // FIFO storage; contents need no reset since the pointers gate them.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_q[AW-1:0]] <= {bus.in_dst[gi*WIDTH_SEL +: WIDTH_SEL],
                                            bus.in_data[gi*DATA_W +: DATA_W]};
                end
            end

            // Pointer and output-slot registers; reset discards stored words.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_q   <= '0;
                    rd_q   <= '0;
                    slot_q <= '0;
                end else begin
                    wr_q   <= wr_d;
                    rd_q   <= rd_d;
                    slot_q <= slot_d;
                end
            end

`ifdef SWITCH_IN_DROP_CNT_EN
            logic [15:0] cnt_q, cnt_d;

            // Count offered-while-full cycles, sticking at all-ones.
            always_comb begin
                cnt_d = cnt_q;
                if (bus.in_valid[gi] && full && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Drop counter register, cleared only by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign drop_cnt[gi*16 +: 16] = cnt_q;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_switch_in_stage.sv
// tb_switch_in_stage: directed scenarios plus randomized traffic for
// switch_in_stage (N=8, D=8, FIFO_DEPTH=4), checked every cycle against a
// queue-based reference model of the ingress stage.
module tb_switch_in_stage;
    localparam int N     = 8;
    localparam int D     = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 3;
    localparam int PW    = 1 + 2 * SW + D;
    localparam int WW    = SW + D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_in_stage_if #(.N(N), .D(D)) bus ();

`ifdef SWITCH_IN_DROP_CNT_EN
    logic [N*16-1:0] drop_cnt;
`endif

    switch_in_stage #(
        .PORT_NUM   (N),
        .DATA_W     (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef SWITCH_IN_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue of {dst,data} per port, expected slots,
    // expected select and drop counts.
    logic [WW-1:0] mq [N][$];
    logic [PW-1:0] m_slot [N];
    int            m_sel;
    int            m_drop [N];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*PW-1:0] model_port();
        logic [N*PW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*PW +: PW] = m_slot[i];
        return v;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_slot[i] = '0;
            m_drop[i] = 0;
        end
        m_sel = 0;
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.port_out", tag), 128'(bus.port_out), 128'(model_port()));
        check($sformatf("%s.sel_out", tag), 128'(bus.sel_out), 128'(m_sel));
        check($sformatf("%s.in_ready", tag), 128'(bus.in_ready), 128'(model_ready()));
`ifdef SWITCH_IN_DROP_CNT_EN
        begin
            logic [N*16-1:0] e = '0;
            for (int i = 0; i < N; i++) e[i*16 +: 16] = 16'(m_drop[i]);
            check($sformatf("%s.drop_cnt", tag), 128'(drop_cnt), 128'(e));
        end
`endif
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic e, input logic [N-1:0] v,
                        input logic [N*SW-1:0] dst, input logic [N*D-1:0] dat);
        bus.en       = e;
        bus.in_valid = v;
        bus.in_dst   = dst;
        bus.in_data  = dat;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            bit was_full;
            was_full = (mq[i].size() == DEPTH);
            if (e && mq[i].size() > 0) m_slot[i] = {1'b1, SW'(i), mq[i].pop_front()};
            else                        m_slot[i] = '0;
            if (v[i]) begin
                if (was_full) begin
                    if (m_drop[i] < 65535) m_drop[i]++;
                end else begin
                    mq[i].push_back({dst[i*SW +: SW], dat[i*D +: D]});
                end
            end
        end
        if (e) m_sel = (m_sel + 1) % N;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic e);
        step(tag, e, '0, '0, '0);
    endtask

    initial begin
        logic [N*SW-1:0] dst;
        logic [N*D-1:0]  dat;
        logic [N*PW-1:0] exp_port;
        logic [PW-1:0]   exp_slot0 [5];

        bus.en = 1'b0; bus.in_valid = '0; bus.in_dst = '0; bus.in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("por");

        // 1. Reset mid-traffic, asynchronous effect and state after release.
        for (int k = 0; k < 6; k++)
            step("pre_rst", 1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom),
                 {$urandom, $urandom});
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("post_rst", 1'b0);
        check("rst.in_ready", 128'(bus.in_ready), 128'(8'hFF));
        check("rst.sel_out", 128'(bus.sel_out), 128'(0));
        check("rst.port_out", 128'(bus.port_out), 128'(0));

        // 4. Select wrap then hold.
        for (int k = 0; k < 10; k++) begin
            idle("wrap", 1'b1);
            check($sformatf("wrap.sel%0d", k), 128'(bus.sel_out), 128'((k + 1) % N));
        end
        for (int k = 0; k < 3; k++) begin
            logic [N-1:0] vb;
            idle("hold", 1'b0);
            for (int i = 0; i < N; i++) vb[i] = bus.port_out[i*PW + PW - 1];
            check("hold.sel", 128'(bus.sel_out), 128'(2));
            check("hold.valid", 128'(vb), 128'(0));
        end

        // 2. Single word on port 2.
        dst = '0; dat = '0;
        dst[2*SW +: SW] = 3'd5;
        dat[2*D +: D]   = 8'hA5;
        step("single_push", 1'b1, 8'h04, dst, dat);
        idle("single_pop", 1'b1);
        exp_port = '0;
        exp_port[2*PW +: PW] = 15'h55A5;
        check("single.port_out", 128'(bus.port_out), 128'(exp_port));

        // 3. Fill port 0 with en low, fifth word dropped, then drain.
        for (int k = 0; k < 5; k++) begin
            dat = '0;
            dat[7:0] = 8'(k + 1);
            step("fill", 1'b0, 8'h01, '0, dat);
            if (k >= 3) check($sformatf("fill.ready%0d", k), 128'(bus.in_ready[0]), 128'(0));
        end
        exp_slot0 = '{15'h4001, 15'h4002, 15'h4003, 15'h4004, 15'h0000};
        for (int k = 0; k < 5; k++) begin
            idle("drain", 1'b1);
            check($sformatf("drain.slot0_%0d", k), 128'(bus.port_out[PW-1:0]), 128'(exp_slot0[k]));
        end
`ifdef SWITCH_IN_DROP_CNT_EN
        check("fill.drop0", 128'(drop_cnt[15:0]), 128'(1));
`endif

        // 5. Concurrent push/pop on port 7 with two words resident.
        for (int k = 0; k < 5; k++) begin
            dst = '0; dat = '0;
            dst[7*SW +: SW] = 3'(k);
            dat[7*D +: D]   = 8'h71 + 8'(k);
            step("conc", (k >= 2), 8'h80, dst, dat);
        end
        for (int k = 0; k < 3; k++) idle("conc_drain", 1'b1);

        // Randomized traffic with long and short enable patterns.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] v;
            v = 8'($urandom) & 8'($urandom | $urandom);
            step("rand", ($urandom_range(0, 3) != 0) && (k % 50 < 40), v, 24'($urandom),
                 {$urandom, $urandom});
        end

`ifdef SWITCH_IN_DROP_CNT_EN
        // 6. Saturation of port 3's drop counter.
        for (int k = 0; k < 66000; k++) step("sat", 1'b0, 8'h08, '0, '0);
        check("sat.drop3", 128'(drop_cnt[63:48]), 128'(16'hFFFF));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
